sim_supervisor: RTL and testbench
=================================

Name: sim_supervisor

Overview:
- Parametrised run-control block that replaces hard-coded reset/run/finish sequencing around `Core`.
- Sequences the core reset and counts run cycles.
- Monitors data-memory stores for a "tohost" completion write and reports pass, fail or timeout with the exit code and cycle count.
- Sits beside `Core`, driving its `rst_i` and snooping the data-memory store port; synthesizable so it also runs on FPGA.

Parameters:
- ADDR_W, 32, store address width
- DATA_W, 32, store data width
- TOHOST_ADDR, 32'h0000_1000, byte address of completion mailbox
- RST_CYCLES, 2, cycles core reset is held after start (>=1)
- TIMEOUT_CYCLES, 100, maximum RUN cycles; 0 disables timeout
- CNT_W, 32, cycle counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a run (sampled in IDLE or DONE)
- st_valid_i  in  1  data-memory store strobe from core
- st_addr_i  in  ADDR_W  store address
- st_data_i  in  DATA_W  store data
- core_rst_o  out  1  active-high reset to Core
- running_o  out  1  high in RUN
- done_o  out  1  high in DONE
- pass_o  out  1  DONE via tohost, exit code 0
- fail_o  out  1  DONE via tohost, exit code != 0
- timeout_o  out  1  DONE via timeout
- exit_code_o  out  DATA_W-1  st_data_i[DATA_W-1:1] of completing store
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed

Behaviour:
- rst_i low, asynchronous: state=IDLE; core_rst_o=1; all other outputs 0. Reset mid-run aborts immediately; no result is retained.
- States: IDLE, RESET, RUN, DONE. All outputs are registered or decoded from state registers; no combinational input-to-output path.
- IDLE: core_rst_o=1. start_i=1 -> RESET on next edge.
- RESET:
  - core_rst_o=1 for exactly RST_CYCLES cycles, using a dedicated counter.
  - cycle_cnt_o, exit_code_o and flags are cleared on entry.
  - Then -> RUN. start_i is ignored.
- RUN:
  - core_rst_o=0; running_o=1.
  - cycle_cnt_o=0 in the first RUN cycle and increments by 1 every RUN cycle, saturating at all-ones.
  - Hit = st_valid_i && st_addr_i==TOHOST_ADDR && st_data_i[0]==1. A store to TOHOST_ADDR with bit0=0 is ignored, as are stores to other addresses.
  - On hit: -> DONE. exit_code_o<=st_data_i[DATA_W-1:1]. pass_o<=(code==0), fail_o<=(code!=0).
  - Timeout: TIMEOUT_CYCLES!=0 && cycle_cnt_o==TIMEOUT_CYCLES-1 with no hit in that cycle -> DONE, timeout_o<=1.
  - Hit and timeout in the same cycle: hit wins; timeout_o stays 0.
  - start_i is ignored.
- DONE:
  - core_rst_o=1 (freezes core); done_o=1.
  - Exactly one of pass_o, fail_o, timeout_o is 1.
  - cycle_cnt_o holds the count of the final RUN cycle, i.e. cycles run minus 1.
  - Store inputs are ignored.
  - start_i=1 -> RESET (rerun); flags and done_o drop on that edge.
- Flag latency: flags rise on the edge following the qualifying RUN cycle.
- Comparator uses full ADDR_W; no masking or alignment.

Test Plan:
- Reset check: hold rst_i=0 mid-clock -> core_rst_o=1, done_o=0, cycle_cnt_o=0 immediately, asynchronously.
- Pass run: start_i pulse, then store 0x1000 / 0x00000001 in RUN cycle 37 -> core_rst_o high for 2 cycles, then low. Then done_o=1, pass_o=1, exit_code_o=0, cycle_cnt_o=37, core_rst_o=1.
- Fail run: store 0x1000 / 0x0000000B -> fail_o=1, exit_code_o=5.
- Non-qualifying stores: store 0x1000 / 0x00000002 and 0x1004 / 0x00000001 -> ignored. Run reaches timeout at cycle 99: timeout_o=1, cycle_cnt_o=99.
- Tie case: qualifying hit exactly in cycle 99 -> pass_o=1, timeout_o=0. TIMEOUT_CYCLES=0 with no hit for 500 cycles -> still RUN.
- Rerun and abort: start_i in DONE -> new RESET, flags clear, count restarts at 0. rst_i low in RUN cycle 10 -> IDLE, core_rst_o=1.

Source files
------------

// File: rtl/sim_supervisor.sv
// Run-control supervisor for Core: sequences its reset, counts run cycles and
// watches data-memory stores for a tohost completion write or a timeout.
module sim_supervisor #(
    parameter int unsigned        ADDR_W         = 32,
    parameter int unsigned        DATA_W         = 32,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = 'h0000_1000,
    parameter int unsigned        RST_CYCLES     = 2,
    parameter int unsigned        TIMEOUT_CYCLES = 100,
    parameter int unsigned        CNT_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              st_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic              core_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [DATA_W-2:0] exit_code_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    localparam int unsigned       RST_W        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0]  RST_LAST     = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic             hit;
    logic             timeout_hit;

    // A completion is a tohost store with bit 0 set; the remaining bits carry the exit code.
    assign hit         = st_valid_i && (st_addr_i == TOHOST_ADDR) && st_data_i[0];
    assign timeout_hit = TIMEOUT_EN && (cycle_cnt_o == TIMEOUT_LAST);

    // Core is held in reset everywhere except RUN, which also freezes it in DONE.
    assign core_rst_o = (state != S_RUN);
    assign running_o  = (state == S_RUN);
    assign done_o     = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_cnt_o <= '0;
            exit_code_o <= '0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state       <= S_RESET;
                        rst_cnt     <= '0;
                        cycle_cnt_o <= '0;
                        exit_code_o <= '0;
                        pass_o      <= 1'b0;
                        fail_o      <= 1'b0;
                        timeout_o   <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state <= S_RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // Hit takes priority over a coincident timeout; the count then holds.
                    if (hit) begin
                        state       <= S_DONE;
                        exit_code_o <= st_data_i[DATA_W-1:1];
                        pass_o      <= (st_data_i[DATA_W-1:1] == '0);
                        fail_o      <= (st_data_i[DATA_W-1:1] != '0);
                    end else if (timeout_hit) begin
                        state     <= S_DONE;
                        timeout_o <= 1'b1;
                    end else if (!(&cycle_cnt_o)) begin
                        cycle_cnt_o <= cycle_cnt_o + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_supervisor.sv
// Scoreboard bench for sim_supervisor: directed runs push expected results,
// a negedge monitor pops and compares whenever done_o rises.
module tb_sim_supervisor;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [30:0] code;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    logic        core_rst, running, done, pass, fail, tmo;
    logic [30:0] exit_code;
    logic [31:0] cycle_cnt;

    logic        nt_core_rst, nt_running, nt_done, nt_pass, nt_fail, nt_tmo;
    logic [30:0] nt_exit_code;
    logic [31:0] nt_cycle_cnt;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    logic done_seen = 1'b0;

    always #5 clk = ~clk;

    sim_supervisor dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
        .core_rst_o(core_rst), .running_o(running), .done_o(done),
        .pass_o(pass), .fail_o(fail), .timeout_o(tmo),
        .exit_code_o(exit_code), .cycle_cnt_o(cycle_cnt)
    );

    sim_supervisor #(.TIMEOUT_CYCLES(0)) dut_nt (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .st_valid_i(st_valid), .st_addr_i(st_addr), .st_data_i(st_data),
        .core_rst_o(nt_core_rst), .running_o(nt_running), .done_o(nt_done),
        .pass_o(nt_pass), .fail_o(nt_fail), .timeout_o(nt_tmo),
        .exit_code_o(nt_exit_code), .cycle_cnt_o(nt_cycle_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic f, input logic t,
                        input logic [30:0] code, input logic [31:0] cnt);
        exp_t e;
        e.pass = p; e.fail = f; e.tmo = t; e.code = code; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        step(1);
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
    endtask

    // Called one tick after an edge with the DUT in IDLE or DONE; returns in RUN cycle 0.
    task automatic start_run(input string tag);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check({tag, " reset1 core_rst"}, core_rst, 1);
        check({tag, " reset1 flags"}, {done, pass, fail, tmo}, 4'b0000);
        check({tag, " reset1 cycle_cnt"}, cycle_cnt, 0);
        check({tag, " reset1 exit_code"}, exit_code, 0);
        step(1);
        check({tag, " reset2 core_rst/running"}, {core_rst, running}, 2'b10);
        step(1);
        check({tag, " run0 core_rst/running"}, {core_rst, running}, 2'b01);
        check({tag, " run0 cycle_cnt"}, cycle_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (done && !done_seen) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done_o=1, expected no completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result pass_o", pass, e.pass);
                check("result fail_o", fail, e.fail);
                check("result timeout_o", tmo, e.tmo);
                check("result exit_code", exit_code, e.code);
                check("result cycle_cnt", cycle_cnt, e.cnt);
                check("result core_rst", core_rst, 1);
            end
        end
        done_seen = done;
    end

    initial begin
        // Asynchronous reset asserted mid-cycle before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("async reset core_rst", core_rst, 1);
        check("async reset outputs", {running, done, pass, fail, tmo}, 5'b0);
        check("async reset cycle_cnt", cycle_cnt, 0);
        step(2);
        rst = 1'b1;
        step(1);
        check("idle core_rst/running", {core_rst, running, done}, 3'b100);

        // Pass run: exit code 0 in RUN cycle 37.
        start_run("pass");
        push(1'b1, 1'b0, 1'b0, 31'd0, 32'd37);
        step(37);
        store(32'h0000_1000, 32'h0000_0001);
        check("pass done/running", {done, running}, 2'b10);

        // Fail run restarted from DONE: exit code 5.
        start_run("fail");
        push(1'b0, 1'b1, 1'b0, 31'd5, 32'd12);
        step(12);
        store(32'h0000_1000, 32'h0000_000B);
        check("fail done", done, 1);
        store(32'h0000_1000, 32'h0000_0003);
        check("done ignores store exit_code", exit_code, 5);
        check("done ignores store flags", {done, pass, fail}, 3'b101);

        // Non-qualifying stores, then timeout at cycle 99.
        start_run("tmo");
        push(1'b0, 1'b0, 1'b1, 31'd0, 32'd99);
        step(5);
        store(32'h0000_1000, 32'h0000_0002);
        store(32'h0000_1004, 32'h0000_0001);
        check("non-qualifying stores ignored", {running, done}, 2'b10);
        step(92);
        check("tmo cycle 99 still running", running, 1);
        check("tmo cycle 99 count", cycle_cnt, 99);
        step(1);
        check("tmo done/timeout", {done, tmo}, 2'b11);
        step(400);
        check("no-timeout instance running", {nt_running, nt_done, nt_tmo}, 3'b100);
        check("no-timeout instance count", nt_cycle_cnt, 500);

        // Hit and timeout coincide in cycle 99: hit wins.
        start_run("tie");
        push(1'b1, 1'b0, 1'b0, 31'd0, 32'd99);
        step(99);
        store(32'h0000_1000, 32'h0000_0001);
        check("tie pass/timeout", {done, pass, tmo}, 3'b110);

        // Abort in RUN cycle 10 with an asynchronous reset.
        start_run("abort");
        step(10);
        check("abort cycle 10 count", cycle_cnt, 10);
        #2 rst = 1'b0;
        #1;
        check("abort core_rst/running", {core_rst, running}, 2'b10);
        check("abort outputs cleared", {done, pass, fail, tmo}, 4'b0);
        check("abort cycle_cnt", cycle_cnt, 0);
        step(1);
        rst = 1'b1;
        step(3);
        check("after abort idle", {core_rst, running, done}, 3'b100);

        check("completions seen", n_done, 4);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
